// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and counter width. Used by the E-stage controller and hazard unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Wide enough for any practical latency setting.
    localparam int CNT_W = 8;

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: 64-bit {hi,lo} result from the latched
// operands and op. wr_en is low when the result must not be written back
// (divide by zero, or an op that is not a multiply/divide).
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [2:0]  op,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        wr_en
);

    mdu_op_e     op_e;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign op_e = mdu_op_e'(op);

    // Division works on magnitudes so that 0x80000000 / -1 wraps to
    // 0x80000000 with a zero remainder instead of overflowing.
    always_comb begin
        is_signed = (op_e == OP_DIV);
        a_neg     = is_signed && a[31];
        b_neg     = is_signed && b[31];
        a_mag     = a_neg ? (32'd0 - a) : a;
        b_mag     = b_neg ? (32'd0 - b) : b;
        divisor   = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag     = a_mag / divisor;
        r_mag     = a_mag % divisor;
        quot      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem       = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    always_comb begin
        a_ext  = {32'd0, a};
        b_ext  = {32'd0, b};
        result = 64'd0;
        wr_en  = 1'b0;
        case (op_e)
            OP_MULT: begin
                a_ext  = {{32{a[31]}}, a};
                b_ext  = {{32{b[31]}}, b};
                result = a_ext * b_ext;
                wr_en  = 1'b1;
            end
            OP_MULTU: begin
                result = a_ext * b_ext;
                wr_en  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                result = {rem, quot};
                wr_en  = (b != 32'd0);
            end
            default: begin
                result = 64'd0;
                wr_en  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Build option: define MDU_FAST_MULT_EN to make MULT/MULTU complete with a
// single busy cycle; divide timing is unchanged by it.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef MDU_FAST_MULT_EN
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
`endif
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [2:0]       op_q;
    logic [63:0]      result;
    logic             wr_en;
    mdu_op_e          op_e;

    assign op_e = mdu_op_e'(op);
    assign busy = (cnt != '0);

    mdu_arith u_arith (
        .a      (a_q),
        .op     (op_q),
        .b      (b_q),
        .result (result),
        .wr_en  (wr_en)
    );

    // Counter, operand latches and HI/LO; new ops are only taken while idle,
    // so a start on the completing edge is ignored until the next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            hi   <= 32'd0;
            lo   <= 32'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            op_q <= OP_NONE;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if ((cnt == CNT_W'(1)) && wr_en) begin
                hi <= result[63:32];
                lo <= result[31:0];
            end
        end else if (start) begin
            case (op_e)
                OP_MULT, OP_MULTU: begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= op;
                    cnt  <= MULT_N;
                end
                OP_DIV, OP_DIVU: begin
                    a_q  <= a;
                    b_q  <= b;
                    op_q <= op;
                    cnt  <= DIV_N;
                end
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                default: ;
            endcase
        end
    end

endmodule
